// File: rtl/wb_demux_4ch.sv
// Registered 1-to-4 demultiplexer for {tag, data} items with a one-entry holding
// register per channel; unicast by select or broadcast to all four channels.
module wb_demux_4ch #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [1:0]          in_sel_i,
    input  logic                in_bcast_i,
    input  logic [TAG_W-1:0]    in_tag_i,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic [3:0]          out_valid_o,
    input  logic [3:0]          out_ready_i,
    output logic [4*TAG_W-1:0]  out_tag_o,
    output logic [4*DATA_W-1:0] out_data_o,
    output logic                busy_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // Ready never looks at valid; a producer holds its item stable until it transfers.
    logic [3:0] can_take;
    logic [3:0] target;
    logic [3:0] load;
    logic       accept;

    // A slot that drains this cycle can be refilled in the same cycle.
    always_comb begin
        can_take   = ~out_valid_o | out_ready_i;
        in_ready_o = in_bcast_i ? (&can_take) : can_take[in_sel_i];
        accept     = in_valid_i & in_ready_o;
        target     = in_bcast_i ? 4'b1111 : (4'b0001 << in_sel_i);
        load       = target & {4{accept}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o <= '0;
            out_tag_o   <= '0;
            out_data_o  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    out_valid_o[k]                 <= 1'b1;
                    out_tag_o[k*TAG_W +: TAG_W]    <= in_tag_i;
                    out_data_o[k*DATA_W +: DATA_W] <= in_data_i;
                end else if (out_ready_i[k]) begin
                    // Payload is left in place after a drain; only valid drops.
                    out_valid_o[k] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = |out_valid_o;

endmodule

// File: tb/tb_wb_demux_4ch.sv
// Directed plus short random stimulus for wb_demux_4ch, checked against a
// per-channel expected queue and directed immediate assertions.
module tb_wb_demux_4ch;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int IW     = TAG_W + DATA_W;

    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [1:0]          in_sel_i = '0;
    logic                in_bcast_i = 1'b0;
    logic [TAG_W-1:0]    in_tag_i = '0;
    logic [DATA_W-1:0]   in_data_i = '0;
    logic [3:0]          out_valid_o;
    logic [3:0]          out_ready_i = '0;
    logic [4*TAG_W-1:0]  out_tag_o;
    logic [4*DATA_W-1:0] out_data_o;
    logic                busy_o;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    logic [IW-1:0] exp_q[4][$];

    wb_demux_4ch #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_sel_i    (in_sel_i),
        .in_bcast_i  (in_bcast_i),
        .in_tag_i    (in_tag_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_tag_o   (out_tag_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_item(input logic [1:0] sel, input logic bcast,
                              input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        in_valid_i = 1'b1;
        in_sel_i   = sel;
        in_bcast_i = bcast;
        in_tag_i   = tag;
        in_data_i  = data;
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        in_bcast_i = 1'b0;
    endtask

    // Scoreboard: compare outputs against the queues, then advance the model
    // by what the coming rising edge will do.
    always @(negedge clk_i) begin
        logic [3:0] m_take;
        logic [3:0] m_tgt;
        logic       m_ready;
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("ch%0d_valid", k), 64'(out_valid_o[k]), 64'(exp_q[k].size() != 0));
                if (out_valid_o[k] && exp_q[k].size() != 0)
                    check($sformatf("ch%0d_item", k),
                          64'({out_tag_o[k*TAG_W +: TAG_W], out_data_o[k*DATA_W +: DATA_W]}),
                          64'(exp_q[k][0]));
            end
        end
        for (int k = 0; k < 4; k++)
            m_take[k] = (exp_q[k].size() == 0) || out_ready_i[k];
        m_ready = in_bcast_i ? (&m_take) : m_take[in_sel_i];
        if (armed)
            check("in_ready_model", 64'(in_ready_o), 64'(m_ready));
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
        end else begin
            m_tgt = in_bcast_i ? 4'b1111 : (4'b0001 << in_sel_i);
            for (int k = 0; k < 4; k++)
                if (exp_q[k].size() != 0 && out_ready_i[k]) void'(exp_q[k].pop_front());
            if (in_valid_i && m_ready)
                for (int k = 0; k < 4; k++)
                    if (m_tgt[k]) exp_q[k].push_back({in_tag_i, in_data_i});
        end
    end

    initial begin
        // 1: reset held two cycles with an item offered
        rst_n_i = 1'b0;
        drive_item(2'd0, 1'b0, 5'h0A, 32'h0000_1111);
        step();
        step();
        armed = 1'b1;
        @(negedge clk_i);
        check("rst_valid", 64'(out_valid_o), 64'h0);
        check("rst_tag", 64'(out_tag_o), 64'h0);
        check("rst_data_lo", out_data_o[63:0], 64'h0);
        check("rst_data_hi", out_data_o[127:64], 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_ready", 64'(in_ready_o), 64'h1);

        // 2: unicast to ch2, then a second item is back-pressured
        step();
        rst_n_i = 1'b1;
        idle();
        out_ready_i = 4'b0000;
        drive_item(2'd2, 1'b0, 5'h1F, 32'hDEAD_BEEF);
        step();
        idle();
        @(negedge clk_i);
        check("uni_valid", 64'(out_valid_o), 64'h4);
        check("uni_tag", 64'(out_tag_o[2*TAG_W +: TAG_W]), 64'h1F);
        check("uni_data", 64'(out_data_o[2*DATA_W +: DATA_W]), 64'hDEAD_BEEF);
        check("uni_busy", 64'(busy_o), 64'h1);
        step();
        drive_item(2'd2, 1'b0, 5'h03, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("held_ready", 64'(in_ready_o), 64'h0);
            check("held_data", 64'(out_data_o[2*DATA_W +: DATA_W]), 64'hDEAD_BEEF);
            step();
        end
        out_ready_i = 4'b0100;
        @(negedge clk_i);
        check("release_ready", 64'(in_ready_o), 64'h1);
        step();
        idle();
        @(negedge clk_i);
        check("second_data", 64'(out_data_o[2*DATA_W +: DATA_W]), 64'hCAFE_F00D);
        step();
        out_ready_i = 4'b0000;

        // 3: back-to-back stream of 8 items to ch1
        out_ready_i = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            drive_item(2'd1, 1'b0, TAG_W'(i), $urandom());
            @(negedge clk_i);
            check("stream_ready", 64'(in_ready_o), 64'h1);
            step();
        end
        idle();
        step();
        step();
        out_ready_i = 4'b0000;

        // 4: broadcast blocked by full ch3, then released
        drive_item(2'd3, 1'b0, 5'h07, 32'hAAAA_0003);
        step();
        out_ready_i = 4'b0111;
        drive_item(2'd0, 1'b1, 5'h11, 32'h1234_5678);
        @(negedge clk_i);
        check("bcast_blocked", 64'(in_ready_o), 64'h0);
        step();
        @(negedge clk_i);
        check("bcast_others", 64'(out_valid_o), 64'h8);
        out_ready_i = 4'b1111;
        @(negedge clk_i);
        check("bcast_ready", 64'(in_ready_o), 64'h1);
        step();
        idle();
        out_ready_i = 4'b0000;
        @(negedge clk_i);
        check("bcast_valid", 64'(out_valid_o), 64'hF);
        for (int k = 0; k < 4; k++)
            check($sformatf("bcast_data%0d", k), 64'(out_data_o[k*DATA_W +: DATA_W]), 64'h1234_5678);

        // 5: ch0 drains and reloads while ch1 drains
        step();
        out_ready_i = 4'b0011;
        drive_item(2'd0, 1'b0, 5'h15, 32'h5555_0000);
        @(negedge clk_i);
        check("sim_ready", 64'(in_ready_o), 64'h1);
        step();
        idle();
        out_ready_i = 4'b0000;
        @(negedge clk_i);
        check("sim_valid", 64'(out_valid_o), 64'hD);
        check("sim_ch0", 64'(out_data_o[DATA_W-1:0]), 64'h5555_0000);
        check("sim_ch1_kept", 64'(out_data_o[DATA_W +: DATA_W]), 64'h1234_5678);

        // 6: all channels full, reset for one cycle with a broadcast offered
        step();
        out_ready_i = 4'b1111;
        drive_item(2'd0, 1'b1, 5'h1B, 32'h0BAD_F00D);
        step();
        idle();
        out_ready_i = 4'b0000;
        @(negedge clk_i);
        check("full_valid", 64'(out_valid_o), 64'hF);
        step();
        rst_n_i = 1'b0;
        drive_item(2'd0, 1'b1, 5'h1C, 32'hFEED_FACE);
        step();
        rst_n_i = 1'b1;
        idle();
        @(negedge clk_i);
        check("mid_rst_valid", 64'(out_valid_o), 64'h0);
        check("mid_rst_busy", 64'(busy_o), 64'h0);
        check("mid_rst_data", out_data_o[63:0], 64'h0);
        out_ready_i = 4'b1111;
        step();
        step();

        // Random traffic against the scoreboard
        for (int i = 0; i < 60; i++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_sel_i    = 2'($urandom_range(0, 3));
            in_bcast_i  = ($urandom_range(0, 5) == 0);
            in_tag_i    = TAG_W'($urandom());
            in_data_i   = $urandom();
            out_ready_i = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        out_ready_i = 4'b1111;
        step();
        step();
        @(negedge clk_i);
        check("drain_idle", 64'(busy_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
